// File: rtl/tempsens_meas_scheduler.sv
// tempsens_meas_scheduler
// Sequences the ring-oscillator temperature measurement: clears the edge
// counter, gates the oscillator for GATE_CYCLES clocks, lets the counter
// synchronizer settle and then accumulates the count. After 2^NSAMP_LOG2
// windows it publishes the average and streams it to the UART, low byte
// first. It is controlled by single-byte UART commands: 'S' runs one result,
// 'C' runs continuously, 'P' stops after the frame in progress.
//
// Ports:
//   i_clk, i_reset      clock, synchronous active-high reset
//   i_rx_ready/i_rx_data command byte strobe from the UART receiver
//   i_count             edge counter value, stable while o_osc_en=0
//   i_tx_busy           UART transmitter busy
//   o_osc_en, o_cnt_clr oscillator/counter enable and counter clear pulse
//   o_tx_start/o_tx_data UART send strobe and byte
//   o_busy              high whenever the scheduler is not idle
//   o_result/o_result_valid averaged result and its update pulse
module tempsens_meas_scheduler #(
    parameter int GATE_CYCLES = 1000,
    parameter int CNT_W       = 16,
    parameter int NSAMP_LOG2  = 3,
    parameter int IDLE_GAP    = 100
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_rx_ready,
    input  logic [7:0]       i_rx_data,
    input  logic [CNT_W-1:0] i_count,
    input  logic             i_tx_busy,
    output logic             o_osc_en,
    output logic             o_cnt_clr,
    output logic             o_tx_start,
    output logic [7:0]       o_tx_data,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_result,
    output logic             o_result_valid
);

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_CLEAR   = 4'd1,
        ST_GATE    = 4'd2,
        ST_SETTLE  = 4'd3,
        ST_ACCUM   = 4'd4,
        ST_DONE    = 4'd5,
        ST_SEND_LO = 4'd6,
        ST_WAIT_LO = 4'd7,
        ST_SEND_HI = 4'd8,
        ST_WAIT_HI = 4'd9,
        ST_GAP     = 4'd10
    } state_t;

    localparam int TMAX  = (GATE_CYCLES > IDLE_GAP) ? GATE_CYCLES : IDLE_GAP;
    localparam int TW    = $clog2(TMAX + 1);
    localparam int ACC_W = CNT_W + NSAMP_LOG2;

    localparam logic [TW-1:0] GATE_LAST   = TW'(GATE_CYCLES - 1);
    localparam logic [TW-1:0] SETTLE_LAST = TW'(1);
    localparam logic [TW-1:0] GAP_LAST    = TW'(IDLE_GAP - 1);
    localparam logic [TW-1:0] TMR_SAT     = {TW{1'b1}};
    localparam logic [4:0]    LAST_IDX    = 5'((1 << NSAMP_LOG2) - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [TW-1:0]       r_tmr;
    logic [ACC_W-1:0]    r_acc;
    logic [4:0]          r_idx;
    logic                r_cont;
    logic                w_cmd_start;
    logic                w_cont_nxt;
    logic                w_osc_en;
    logic                w_cnt_clr;
    logic                w_tx_start;
    logic                w_busy;
    logic [15:0]         w_res16;

    // Command decode; a 'P' wins over the frame in progress but never aborts it.
    always_comb begin
        w_cmd_start = 1'b0;
        w_cont_nxt  = r_cont;
        if (i_rx_ready) begin
            case (i_rx_data)
                8'h53:   w_cmd_start = 1'b1;
                8'h43: begin
                    w_cmd_start = 1'b1;
                    w_cont_nxt  = 1'b1;
                end
                8'h50:   w_cont_nxt  = 1'b0;
                default: w_cmd_start = 1'b0;
            endcase
        end else begin
            w_cmd_start = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Dwell timer: restarts on every state change, saturates while waiting.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_tmr <= '0;
        end else if (w_state_nxt != r_state) begin
            r_tmr <= '0;
        end else if (r_tmr != TMR_SAT) begin
            r_tmr <= r_tmr + TW'(1);
        end else begin
            r_tmr <= r_tmr;
        end
    end

    // Next-state logic. In WAIT_x the first cycle (r_tmr==0) ignores
    // i_tx_busy because the UART only raises it one cycle after tx_start.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (w_cmd_start) w_state_nxt = ST_CLEAR;
                        else             w_state_nxt = ST_IDLE;
            ST_CLEAR:   w_state_nxt = ST_GATE;
            ST_GATE:    if (r_tmr == GATE_LAST) w_state_nxt = ST_SETTLE;
                        else                    w_state_nxt = ST_GATE;
            ST_SETTLE:  if (r_tmr == SETTLE_LAST) w_state_nxt = ST_ACCUM;
                        else                      w_state_nxt = ST_SETTLE;
            ST_ACCUM:   if (r_idx == LAST_IDX) w_state_nxt = ST_DONE;
                        else                   w_state_nxt = ST_CLEAR;
            ST_DONE:    w_state_nxt = ST_SEND_LO;
            ST_SEND_LO: if (!i_tx_busy) w_state_nxt = ST_WAIT_LO;
                        else            w_state_nxt = ST_SEND_LO;
            ST_WAIT_LO: if ((r_tmr != '0) && !i_tx_busy) w_state_nxt = ST_SEND_HI;
                        else                             w_state_nxt = ST_WAIT_LO;
            ST_SEND_HI: if (!i_tx_busy) w_state_nxt = ST_WAIT_HI;
                        else            w_state_nxt = ST_SEND_HI;
            ST_WAIT_HI: if ((r_tmr != '0) && !i_tx_busy)
                            w_state_nxt = w_cont_nxt ? ST_GAP : ST_IDLE;
                        else
                            w_state_nxt = ST_WAIT_HI;
            ST_GAP:     if (r_tmr == GAP_LAST)
                            w_state_nxt = w_cont_nxt ? ST_CLEAR : ST_IDLE;
                        else
                            w_state_nxt = ST_GAP;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    // Output decode from the next state so the registered outputs line up
    // with the state they belong to.
    always_comb begin
        w_osc_en   = (w_state_nxt == ST_GATE);
        w_cnt_clr  = (w_state_nxt == ST_CLEAR);
        w_busy     = (w_state_nxt != ST_IDLE);
        w_tx_start = ((r_state == ST_SEND_LO) && (w_state_nxt == ST_WAIT_LO)) ||
                     ((r_state == ST_SEND_HI) && (w_state_nxt == ST_WAIT_HI));
    end

    // Control output registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_osc_en   <= 1'b0;
            o_cnt_clr  <= 1'b0;
            o_tx_start <= 1'b0;
            o_busy     <= 1'b0;
        end else begin
            o_osc_en   <= w_osc_en;
            o_cnt_clr  <= w_cnt_clr;
            o_tx_start <= w_tx_start;
            o_busy     <= w_busy;
        end
    end

    assign w_res16 = 16'(o_result);

    // Accumulator, sample index, continuous flag, result and tx byte.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_acc          <= '0;
            r_idx          <= 5'd0;
            r_cont         <= 1'b0;
            o_result       <= '0;
            o_result_valid <= 1'b0;
            o_tx_data      <= 8'd0;
        end else begin
            r_cont         <= w_cont_nxt;
            o_result_valid <= 1'b0;
            if (r_state == ST_ACCUM) begin
                r_acc <= r_acc + ACC_W'(i_count);
                if (r_idx != LAST_IDX) begin
                    r_idx <= r_idx + 5'd1;
                end else begin
                    r_idx <= r_idx;
                end
            end else if (r_state == ST_DONE) begin
                o_result       <= CNT_W'(r_acc >> NSAMP_LOG2);
                o_result_valid <= 1'b1;
                r_acc          <= '0;
                r_idx          <= 5'd0;
            end else begin
                r_acc <= r_acc;
                r_idx <= r_idx;
            end
            // Byte only changes on a send, so it stays put while the UART is busy.
            if (w_tx_start) begin
                o_tx_data <= (r_state == ST_SEND_LO) ? w_res16[7:0] : 8'(w_res16 >> 8);
            end else begin
                o_tx_data <= o_tx_data;
            end
        end
    end

endmodule
